// File: rtl/ring_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ring_pkg                                                    |
// | Brief  : Shared ring packet layout, packet type and sink FSM states. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package ring_pkg;

    localparam int PKT_W     = 49;
    localparam int VALID_BIT = 48;
    localparam int TS_MSB    = 47;
    localparam int TS_LSB    = 32;
    localparam int SRC_MSB   = 31;
    localparam int SRC_LSB   = 16;
    localparam int DST_MSB   = 15;
    localparam int DST_LSB   = 0;

    typedef logic [PKT_W-1:0] packet_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        COOL  = 2'd2
    } sink_state_e;

endpackage : ring_pkg
`default_nettype wire

// File: rtl/ring_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ring_sync_fifo                                              |
// | Brief  : Single-clock FIFO; push into a full FIFO is legal when a    |
// |          pop happens in the same cycle.                              |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module ring_sync_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    // Storage carries no reset; pointers alone define occupancy.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule : ring_sync_fifo
`default_nettype wire

// File: rtl/packet_sink_local.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : packet_sink_local                                           |
// | Brief  : Ring-node ejection endpoint: destination check, buffering,  |
// |          paced draining, backpressure and latency statistics.        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module packet_sink_local
    import ring_pkg::*;
#(
    parameter int NUM_NODES        = 8,
    parameter int ROUTER_ID        = 0,
    parameter int PACKET_SIZE      = 49,
    parameter int BUFFER_SIZE      = 4,
    parameter int EJECT_CYCLE      = 1,
    parameter int BUFFER_THRESHOLD = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            clk_counter,
    input  logic [PACKET_SIZE-1:0] eject_in,
    input  logic                   sink_en,
    output logic                   backpressure_wr,
    output logic [PACKET_SIZE-1:0] eject_out,
    output logic                   eject_out_valid,
    output logic [63:0]            total_packet_recieve,
    output logic [63:0]            total_latency,
    output logic [15:0]            max_latency,
    output logic [31:0]            misroute_cnt,
    output logic [31:0]            overflow_cnt
);

    localparam int          CW          = $clog2(BUFFER_SIZE) + 1;
    localparam int          PW          = (EJECT_CYCLE > 1) ? $clog2(EJECT_CYCLE) : 1;
    localparam logic [15:0] C_ROUTER_ID = 16'(ROUTER_ID % NUM_NODES);

    sink_state_e             r_state;
    sink_state_e             w_next_state;
    logic [PW-1:0]           r_pace;
    logic [PW-1:0]           w_next_pace;
    logic [CW-1:0]           w_count;
    logic [CW-1:0]           w_next_count;
    logic                    w_full;
    logic                    w_empty;
    logic [PACKET_SIZE+15:0] w_head;
    logic [15:0]             w_lat;
    logic [15:0]             w_head_lat;
    logic                    w_valid;
    logic                    w_misroute;
    logic                    w_push;
    logic                    w_overflow;
    logic                    w_pop;

    assign w_valid    = eject_in[VALID_BIT];
    // Modular subtraction yields the right latency across a counter wrap.
    assign w_lat      = clk_counter - eject_in[TS_MSB:TS_LSB];
    assign w_misroute = w_valid && (eject_in[DST_MSB:DST_LSB] != C_ROUTER_ID);
    assign w_pop      = (r_state == READY) && sink_en && !w_empty;
    assign w_push     = w_valid && !w_misroute && (!w_full || w_pop);
    assign w_overflow = w_valid && !w_misroute && !w_push;
    assign w_head_lat = w_head[15:0];

    assign w_next_count = w_count + CW'(w_push) - CW'(w_pop);

    always_comb begin
        w_next_pace = r_pace;
        if (w_pop)             w_next_pace = PW'(EJECT_CYCLE - 1);
        else if (r_pace != '0) w_next_pace = r_pace - 1'b1;
    end

    always_comb begin
        w_next_state = IDLE;
        if (w_next_pace != '0)       w_next_state = COOL;
        else if (w_next_count != '0) w_next_state = READY;
    end

    ring_sync_fifo #(
        .WIDTH (PACKET_SIZE + 16),
        .DEPTH (BUFFER_SIZE)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   ({eject_in, w_lat}),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state              <= IDLE;
            r_pace               <= '0;
            backpressure_wr      <= 1'b0;
            eject_out            <= '0;
            eject_out_valid      <= 1'b0;
            total_packet_recieve <= '0;
            total_latency        <= '0;
            max_latency          <= '0;
            misroute_cnt         <= '0;
            overflow_cnt         <= '0;
        end else begin
            r_state         <= w_next_state;
            r_pace          <= w_next_pace;
            backpressure_wr <= ((BUFFER_SIZE - int'(w_next_count)) < BUFFER_THRESHOLD);
            eject_out_valid <= w_pop;
            if (w_pop) begin
                eject_out            <= w_head[PACKET_SIZE+15:16];
                total_packet_recieve <= total_packet_recieve + 64'd1;
                total_latency        <= total_latency + {48'd0, w_head_lat};
                if (w_head_lat > max_latency) max_latency <= w_head_lat;
            end
            if (w_misroute && (misroute_cnt != '1)) misroute_cnt <= misroute_cnt + 32'd1;
            if (w_overflow && (overflow_cnt != '1)) overflow_cnt <= overflow_cnt + 32'd1;
        end
    end

endmodule : packet_sink_local
`default_nettype wire

// File: tb/tb_packet_sink_local.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_packet_sink_local                                        |
// | Brief  : Scoreboard bench for packet_sink_local (ROUTER_ID=2,        |
// |          EJECT_CYCLE=3, BUFFER_SIZE=4).                              |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_packet_sink_local;

    localparam int PS  = 49;
    localparam int BS  = 4;
    localparam int EC  = 3;
    localparam int RID = 2;

    typedef struct packed {
        logic [PS-1:0] pkt;
        logic [15:0]   lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [15:0]   clk_counter = '0;
    logic [PS-1:0] eject_in = '0;
    logic          sink_en = 1'b0;
    logic          backpressure_wr;
    logic [PS-1:0] eject_out;
    logic          eject_out_valid;
    logic [63:0]   total_packet_recieve;
    logic [63:0]   total_latency;
    logic [15:0]   max_latency;
    logic [31:0]   misroute_cnt;
    logic [31:0]   overflow_cnt;

    exp_t        sb[$];
    int          pop_cyc[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] m_recv = '0;
    logic [63:0] m_tot = '0;
    logic [15:0] m_max = '0;
    exp_t        r_head;

    packet_sink_local #(
        .NUM_NODES        (8),
        .ROUTER_ID        (RID),
        .PACKET_SIZE      (PS),
        .BUFFER_SIZE      (BS),
        .EJECT_CYCLE      (EC),
        .BUFFER_THRESHOLD (1)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .clk_counter          (clk_counter),
        .eject_in             (eject_in),
        .sink_en              (sink_en),
        .backpressure_wr      (backpressure_wr),
        .eject_out            (eject_out),
        .eject_out_valid      (eject_out_valid),
        .total_packet_recieve (total_packet_recieve),
        .total_latency        (total_latency),
        .max_latency          (max_latency),
        .misroute_cnt         (misroute_cnt),
        .overflow_cnt         (overflow_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Pops are compared against the expected-packet queue and a running statistics model.
    always @(negedge clk) begin
        if (rst_n) begin
            sb.delete();
            m_recv = '0;
            m_tot  = '0;
            m_max  = '0;
        end else if (eject_out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_pop", 64'd1, 64'd0);
            end else begin
                r_head = sb.pop_front();
                m_recv = m_recv + 64'd1;
                m_tot  = m_tot + {48'd0, r_head.lat};
                if (r_head.lat > m_max) m_max = r_head.lat;
                pop_cyc.push_back(cyc);
                chk("pop_pkt", {15'd0, eject_out}, {15'd0, r_head.pkt});
                chk("pop_recv", total_packet_recieve, m_recv);
                chk("pop_tot_lat", total_latency, m_tot);
                chk("pop_max_lat", {48'd0, max_latency}, {48'd0, m_max});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one packet for one cycle; returns just after its arrival edge.
    task automatic send(input logic [15:0] ts, input logic [15:0] dst,
                        input logic [15:0] cc, input bit accept);
        exp_t e;
        eject_in    = {1'b1, ts, 16'h00A5, dst};
        clk_counter = cc;
        if (accept) begin
            e.pkt = eject_in;
            e.lat = cc - ts;
            sb.push_back(e);
        end
        tick(1);
        eject_in[48] = 1'b0;
    endtask

    initial begin
        int arr;

        // Reset with garbage on the ejection port.
        rst_n    = 1'b1;
        eject_in = {1'b1, 48'h1234_5678_9ABC};
        clk_counter = 16'h4321;
        tick(3);
        chk("rst_bp", {63'd0, backpressure_wr}, 64'd0);
        chk("rst_out", {15'd0, eject_out}, 64'd0);
        chk("rst_valid", {63'd0, eject_out_valid}, 64'd0);
        chk("rst_recv", total_packet_recieve, 64'd0);
        chk("rst_tot", total_latency, 64'd0);
        chk("rst_max", {48'd0, max_latency}, 64'd0);
        chk("rst_misroute", {32'd0, misroute_cnt}, 64'd0);
        chk("rst_overflow", {32'd0, overflow_cnt}, 64'd0);

        // Queue three, then reset before any drain.
        eject_in = '0;
        rst_n    = 1'b0;
        sink_en  = 1'b0;
        send(16'd10, 16'd2, 16'd40, 1'b1);
        send(16'd20, 16'd2, 16'd40, 1'b1);
        send(16'd30, 16'd2, 16'd40, 1'b1);
        tick(2);
        chk("q3_recv", total_packet_recieve, 64'd0);
        rst_n = 1'b1;
        tick(1);
        rst_n   = 1'b0;
        sink_en = 1'b1;
        tick(6);
        chk("midrst_recv", total_packet_recieve, 64'd0);
        chk("midrst_tot", total_latency, 64'd0);
        chk("midrst_bp", {63'd0, backpressure_wr}, 64'd0);

        // Single packet latency and pop timing.
        send(16'd100, 16'd2, 16'd107, 1'b1);
        chk("t2_valid_early", {63'd0, eject_out_valid}, 64'd0);
        tick(1);
        chk("t2_valid", {63'd0, eject_out_valid}, 64'd1);
        chk("t2_recv", total_packet_recieve, 64'd1);
        chk("t2_tot", total_latency, 64'd7);
        chk("t2_max", {48'd0, max_latency}, 64'd7);
        tick(4);

        // Timestamp wrap.
        send(16'hFFFE, 16'd2, 16'h0003, 1'b1);
        tick(2);
        chk("t3_recv", total_packet_recieve, 64'd2);
        chk("t3_tot", total_latency, 64'd12);
        chk("t3_max", {48'd0, max_latency}, 64'd7);
        tick(4);

        // Misroute.
        send(16'd0, 16'd5, 16'd10, 1'b0);
        chk("t4_misroute", {32'd0, misroute_cnt}, 64'd1);
        tick(4);
        chk("t4_recv", total_packet_recieve, 64'd2);

        // Paced draining of four back-to-back arrivals.
        pop_cyc.delete();
        arr = cyc + 1;
        for (int i = 0; i < 4; i++) send(16'(200 + i), 16'd2, 16'd220, 1'b1);
        tick(12);
        chk("t5_npops", 64'(pop_cyc.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < pop_cyc.size()) chk("t5_pop_time", 64'(pop_cyc[i] - arr), 64'(1 + EC * i));
        end
        tick(4);

        // Overflow with draining frozen, then push-while-full with a pop.
        sink_en = 1'b0;
        for (int i = 0; i < 3; i++) send(16'(300 + i), 16'd2, 16'd310, 1'b1);
        chk("t6_bp_three", {63'd0, backpressure_wr}, 64'd0);
        send(16'd303, 16'd2, 16'd310, 1'b1);
        chk("t6_bp_full", {63'd0, backpressure_wr}, 64'd1);
        send(16'd304, 16'd2, 16'd310, 1'b0);
        chk("t6_overflow", {32'd0, overflow_cnt}, 64'd1);
        sink_en = 1'b1;
        send(16'd305, 16'd2, 16'd320, 1'b1);
        chk("t6_overflow_hold", {32'd0, overflow_cnt}, 64'd1);
        chk("t6_bp_hold", {63'd0, backpressure_wr}, 64'd1);
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
        chk("drain_empty", 64'(sb.size()), 64'd0);
        tick(2);
        chk("final_recv", total_packet_recieve, 64'd11);
        chk("final_misroute", {32'd0, misroute_cnt}, 64'd1);
        chk("final_overflow", {32'd0, overflow_cnt}, 64'd1);
        chk("final_bp", {63'd0, backpressure_wr}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_packet_sink_local
`default_nettype wire
